// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - 16-bit operation sequencer over an 8-bit combinational ALU
//
// Runs each 16-bit request through the external 8-bit ALU in two passes.
// The low byte goes first, then the high byte. The carry is chained
// between the slices for add, sub and lt.
//
// Ports:
//   Clk, Reset            clock; synchronous active-low reset
//   InValid/InReady       request handshake; OpA, OpB, Op are captured at accept
//   OutValid/OutReady     response handshake; Result, CarryOut
//   AluA/AluB/AluOp/AluOverflowIn   drives to the ALU (0 when IDLE or DONE)
//   AluOut/AluOverflowOut           ALU results, sampled at the end of LO and HI
module alu16_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [15:0] OpA,
  input  logic [15:0] OpB,
  input  logic [3:0]  Op,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] Result,
  output logic        CarryOut,
  output logic [7:0]  AluA,
  output logic [7:0]  AluB,
  output logic [3:0]  AluOp,
  output logic        AluOverflowIn,
  input  logic [7:0]  AluOut,
  input  logic        AluOverflowOut
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_LT   = 4'b1101;
  localparam logic [3:0] OP_EQL  = 4'b1110;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [3:0]  op_q;
  logic [7:0]  lo_res;
  logic        lo_c;

  logic is_neg;    // sub and lt: A + ~B + 1
  logic is_arith;  // add, sub, lt share the adder and the carry chain
  logic is_logic;
  logic is_eql;
  logic busy;
  logic [7:0] slice_a;
  logic [7:0] slice_b;

  always_comb begin
    is_neg   = (op_q == OP_SUB) || (op_q == OP_LT);
    is_arith = (op_q == OP_ADD) || is_neg;
    is_logic = (op_q == OP_NAND) || (op_q == OP_OR);
    is_eql   = (op_q == OP_EQL);
    busy     = (state == LO) || (state == HI);
    slice_a  = (state == HI) ? a_q[15:8] : a_q[7:0];
    slice_b  = (state == HI) ? b_q[15:8] : b_q[7:0];
  end

  assign InReady = Reset && (state == IDLE);

  // ALU drives decode from state and the captured request.
  // Unknown opcodes leave every drive at 0.
  always_comb begin
    AluA          = 8'h00;
    AluB          = 8'h00;
    AluOp         = 4'b0000;
    AluOverflowIn = 1'b0;
    if (busy) begin
      if (is_arith) begin
        AluA          = slice_a;
        AluB          = is_neg ? ~slice_b : slice_b;
        AluOp         = OP_ADD;
        AluOverflowIn = (state == LO) ? is_neg : lo_c;
      end else if (is_logic) begin
        AluA  = slice_a;
        AluB  = slice_b;
        AluOp = op_q;
      end else if (is_eql) begin
        AluA  = slice_a;
        AluB  = slice_b;
        AluOp = OP_EQL;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      op_q     <= 4'b0000;
      lo_res   <= 8'h00;
      lo_c     <= 1'b0;
      Result   <= 16'h0000;
      CarryOut <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            a_q   <= OpA;
            b_q   <= OpB;
            op_q  <= Op;
            state <= LO;
          end
        end
        LO: begin
          lo_res <= AluOut;
          lo_c   <= AluOverflowOut;
          state  <= HI;
        end
        HI: begin
          if (op_q == OP_LT) begin
            // Bit 15 of the difference is bit 7 of the high slice.
            Result   <= {15'b0, AluOut[7]};
            CarryOut <= AluOverflowOut;
          end else if (is_arith) begin
            Result   <= {AluOut, lo_res};
            CarryOut <= AluOverflowOut;
          end else if (is_logic) begin
            Result   <= {AluOut, lo_res};
            CarryOut <= 1'b0;
          end else if (is_eql) begin
            Result   <= {15'b0, lo_res[0] & AluOut[0]};
            CarryOut <= 1'b0;
          end else begin
            Result   <= 16'h0000;
            CarryOut <= 1'b0;
          end
          OutValid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb/tb_alu16_sequencer.sv - directed table-driven bench for alu16_sequencer
module tb_alu16_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [3:0]  Op;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Result;
  logic        CarryOut;
  logic [7:0]  AluA;
  logic [7:0]  AluB;
  logic [3:0]  AluOp;
  logic        AluOverflowIn;
  logic [7:0]  AluOut;
  logic        AluOverflowOut;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  alu16_sequencer dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .OpA(OpA), .OpB(OpB), .Op(Op),
    .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .CarryOut(CarryOut),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOverflowIn(AluOverflowIn),
    .AluOut(AluOut), .AluOverflowOut(AluOverflowOut)
  );

  // Behavioural model of the external 8-bit ALU contract
  logic [8:0] sum9;
  always_comb begin
    sum9           = {1'b0, AluA} + {1'b0, AluB} + {8'b0, AluOverflowIn};
    AluOut         = 8'h00;
    AluOverflowOut = 1'b0;
    case (AluOp)
      4'b0000: begin AluOut = sum9[7:0]; AluOverflowOut = sum9[8]; end
      4'b0110: AluOut = ~(AluA & AluB);
      4'b0111: AluOut = AluA | AluB;
      4'b1110: AluOut = (AluA == AluB) ? 8'h01 : 8'h00;
      default: AluOut = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, check latency and result, then complete the handshake.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic [15:0] er, input logic ec);
    int lat;
    @(negedge Clk);
    chk({name, " in_ready"}, {31'b0, InReady}, 32'd1);
    OpA = a; OpB = b; Op = op; InValid = 1'b1; OutReady = 1'b0;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    // Request inputs must be ignored after the accept edge.
    OpA = ~a; OpB = a ^ b; Op = ~op;
    lat = 0;
    while (lat < 8) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
      if (OutValid) break;
    end
    chk({name, " latency"}, lat, 32'd2);
    chk({name, " result"}, {16'b0, Result}, {16'b0, er});
    chk({name, " carry"}, {31'b0, CarryOut}, {31'b0, ec});
    chk({name, " alu idle drives"}, {11'b0, AluA, AluB, AluOp, AluOverflowIn}, 32'd0);
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
    chk({name, " out_valid drop"}, {31'b0, OutValid}, 32'd0);
    chk({name, " in_ready back"}, {31'b0, InReady}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        c;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{"add carry slice", 16'h00FF, 16'h0001, 4'b0000, 16'h0100, 1'b0};
    vecs[1]  = '{"add overflow",    16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 1'b1};
    vecs[2]  = '{"add mixed",       16'h1234, 16'h0F0F, 4'b0000, 16'h2143, 1'b0};
    vecs[3]  = '{"sub borrow slice", 16'h0100, 16'h0001, 4'b0001, 16'h00FF, 1'b1};
    vecs[4]  = '{"sub equal",       16'h0001, 16'h0001, 4'b0001, 16'h0000, 1'b1};
    vecs[5]  = '{"sub negative",    16'h0003, 16'h0005, 4'b0001, 16'hFFFE, 1'b0};
    vecs[6]  = '{"lt true",         16'h0000, 16'h0003, 4'b1101, 16'h0001, 1'b0};
    vecs[7]  = '{"lt false",        16'h0005, 16'h0003, 4'b1101, 16'h0000, 1'b1};
    vecs[8]  = '{"eql match",       16'h1234, 16'h1234, 4'b1110, 16'h0001, 1'b0};
    vecs[9]  = '{"eql lo mismatch", 16'h1234, 16'h1235, 4'b1110, 16'h0000, 1'b0};
    vecs[10] = '{"eql hi mismatch", 16'h1234, 16'h2234, 4'b1110, 16'h0000, 1'b0};
    vecs[11] = '{"nand",            16'h0001, 16'h0001, 4'b0110, 16'hFFFE, 1'b0};
    vecs[12] = '{"or",              16'h0100, 16'h0001, 4'b0111, 16'h0101, 1'b0};
    vecs[13] = '{"bad opcode",      16'h1234, 16'h5678, 4'b1000, 16'h0000, 1'b0};
    vecs[14] = '{"or high",         16'hA500, 16'h5A0F, 4'b0111, 16'hFF0F, 1'b0};

    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    OpA = 16'h0; OpB = 16'h0; Op = 4'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset out_valid", {31'b0, OutValid}, 32'd0);
    chk("reset result", {16'b0, Result}, 32'd0);
    chk("reset carry", {31'b0, CarryOut}, 32'd0);
    chk("reset in_ready low", {31'b0, InReady}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("idle in_ready", {31'b0, InReady}, 32'd1);
    chk("idle alu drives", {11'b0, AluA, AluB, AluOp, AluOverflowIn}, 32'd0);

    for (int i = 0; i < 15; i++)
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].c);

    // Backpressure: DONE holds while new requests and operands are presented.
    @(negedge Clk);
    OpA = 16'h1111; OpB = 16'h2222; Op = 4'b0000; InValid = 1'b1; OutReady = 1'b0;
    begin
      int lat;
      lat = 0;
      @(posedge Clk);
      while (lat < 8) begin
        @(posedge Clk);
        lat++;
        @(negedge Clk);
        OpA = OpA + 16'h0101;
        if (OutValid) break;
      end
      chk("bp latency", lat, 32'd2);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      OpA = 16'h0F00 + 16'(i); OpB = 16'h00F0 + 16'(i);
      chk("bp result stable", {16'b0, Result}, 32'h3333);
      chk("bp out_valid held", {31'b0, OutValid}, 32'd1);
      chk("bp in_ready low", {31'b0, InReady}, 32'd0);
    end
    OpA = 16'h0010; OpB = 16'h0020;
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;
    chk("bp release out_valid", {31'b0, OutValid}, 32'd0);
    chk("bp release in_ready", {31'b0, InReady}, 32'd1);
    // InValid is still high: the next edge accepts 0x0010 + 0x0020.
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("bp next out_valid", {31'b0, OutValid}, 32'd1);
    chk("bp next result", {16'b0, Result}, 32'h0030);
    OutReady = 1'b1;
    @(negedge Clk);
    OutReady = 1'b0;

    // Reset during HI discards the operation.
    @(negedge Clk);
    OpA = 16'h7777; OpB = 16'h1111; Op = 4'b0000; InValid = 1'b1;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("hi carry chained", {31'b0, AluOverflowIn}, 32'd0);
    chk("hi slice a", {24'b0, AluA}, 32'h77);
    Reset = 1'b0;
    @(negedge Clk);
    chk("midreset out_valid", {31'b0, OutValid}, 32'd0);
    chk("midreset result", {16'b0, Result}, 32'd0);
    chk("midreset in_ready low", {31'b0, InReady}, 32'd0);
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("postreset no out_valid", {31'b0, OutValid}, 32'd0);
      chk("postreset in_ready", {31'b0, InReady}, 32'd1);
    end
    do_op("after reset add", 16'h0002, 16'h0003, 4'b0000, 16'h0005, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu16_sequencer.md
# alu16_sequencer

Sequential front end that performs 16-bit operations by driving the existing combinational 8-bit ALU twice per operation, low byte then high byte, chaining `OverflowOut` back into `OverflowIn`. It sits between the datapath issue logic, which uses a valid/ready handshake, and the ALU's `InputA`/`InputB`/`OP`/`OverflowIn` → `Out`/`OverflowOut` interface. It reuses the ALU's 4-bit opcodes.

## Interface
Parameters: none. Width is fixed at 16 bits, split into two 8-bit slices.

Ports:
- `Clk`  in  1  sole clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `InValid`  in  1  request present.
- `InReady`  out  1  block can accept a request.
- `OpA`  in  16  operand A.
- `OpB`  in  16  operand B.
- `Op`  in  4  opcode: 0000 add, 0001 sub, 0110 nand, 0111 or, 1101 lt, 1110 eql.
- `OutValid`  out  1  `Result`/`CarryOut` are valid.
- `OutReady`  in  1  consumer accepts the result.
- `Result`  out  16  operation result.
- `CarryOut`  out  1  high-slice carry (add/sub/lt only).
- `AluA`  out  8  to ALU `InputA`.
- `AluB`  out  8  to ALU `InputB`.
- `AluOp`  out  4  to ALU `OP`.
- `AluOverflowIn`  out  1  to ALU `OverflowIn`.
- `AluOut`  in  8  from ALU `Out`.
- `AluOverflowOut`  in  1  from ALU `OverflowOut`.

The ALU contract relied on: for `OP`=0000, {`OverflowOut`,`Out`} = `InputA` + `InputB` + `OverflowIn`; for 0110, `Out` = ~(A&B); for 0111, `Out` = A|B; for 1110, `Out` = 1 if A==B, else 0.

## Operation
- **FSM states:** `IDLE` → `LO` → `HI` → `DONE` → `IDLE`.
- **IDLE:** `InReady`=1. On `InValid`&`InReady`, register `OpA`, `OpB`, `Op` and go to `LO`.
- **LO:** drive the low slices. Register `AluOut` into `lo_res` and `AluOverflowOut` into `lo_c`. Go to `HI`.
- **HI:** drive the high slices, with `AluOverflowIn` = `lo_c` for add/sub/lt. Register the high result and the final carry. Go to `DONE`.
- **DONE:** `OutValid`=1. `Result` and `CarryOut` are held stable. On `OutReady`=1, go to `IDLE`.
- **IDLE and DONE:** ALU drives are 0: `AluA`=`AluB`=0, `AluOp`=0000, `AluOverflowIn`=0.

Opcode translation, per slice:
- **add:** `AluOp`=0000, B slice unmodified. LO `OverflowIn`=0. `Result`={hi,lo}; `CarryOut`=hi carry.
- **sub:** `AluOp`=0000, B slice inverted (~B). LO `OverflowIn`=1, which gives A + ~B + 1. `Result`=A−B mod 2^16. `CarryOut`=1 means no borrow (A≥B unsigned).
- **lt:** computed exactly as sub. `Result`={15'b0, diff[15]}; `CarryOut` follows sub.
- **nand / or:** `AluOp` passes through, `AluOverflowIn`=0. `Result`={hi,lo}; `CarryOut`=0.
- **eql:** `AluOp`=1110 on both slices. `Result`={15'b0, lo_res[0] & hi_res[0]}; `CarryOut`=0.
- **Any other opcode:** sequences through LO/HI with ALU drives at 0. `Result`=0x0000, `CarryOut`=0. Latency is the same as for valid opcodes.

Rules:
- Request inputs are sampled only at the accept edge. Changes to them afterward have no effect.
- Reset (`Reset`=0 at an edge) from any state:
  - state returns to `IDLE`;
  - an in-flight operation is discarded and produces no `OutValid`;
  - `Result`=0x0000, `CarryOut`=0, `OutValid`=0.
- `InReady`=0 while `Reset` is low. It is 1 in `IDLE` otherwise.

## Timing
- Accept at edge k. LO runs during cycle k→k+1 and HI during k+1→k+2. `OutValid` rises after edge k+2.
- Minimum spacing between accepts is 4 edges: there is no overlap, and `InReady`=0 in `LO`/`HI`/`DONE`.
- Backpressure: `DONE` holds indefinitely with outputs stable while `OutReady`=0.
- `OutValid` falls on the edge where `OutValid`&`OutReady`. `InReady` rises in the same cycle.
- The ALU is combinational. Its outputs are sampled at the end of the `LO` and `HI` cycles only.
- All outputs are registered, except `InReady` and the `Alu*` drives, which decode from the state register and the captured operands.

## Test plan
- **add carry across slices:** `OpA`=0x00FF, `OpB`=0x0001, `Op`=0000 → `Result`=0x0100, `CarryOut`=0. `OutValid` rises 2 edges after accept.
- **add 16-bit overflow:** 0xFFFF + 0x0001 → `Result`=0x0000, `CarryOut`=1. Also 0x1234 + 0x0F0F → 0x2143, `CarryOut`=0.
- **sub/lt:** 0x0100 − 0x0001 → 0x00FF, `CarryOut`=1. 0x0001 − 0x0001 → 0x0000, `CarryOut`=1. lt 0x0000 vs 0x0003 → 0x0001, `CarryOut`=0.
- **eql/nand/or:**
  - eql 0x1234 vs 0x1234 → 0x0001;
  - eql 0x1234 vs 0x1235 → 0x0000 (low-slice mismatch);
  - eql 0x1234 vs 0x2234 → 0x0000 (high-slice mismatch);
  - nand 0x0001,0x0001 → 0xFFFE;
  - or 0x0100,0x0001 → 0x0101;
  - opcode 1000 → 0x0000.
- **Backpressure:** hold `OutReady`=0 for 5 cycles after `OutValid`, with `InValid`=1 and changing operands. `Result` stays stable, `InReady`=0, no second accept. Release → handshake, then the next request is accepted in `IDLE`.
- **Reset mid-operation:** assert `Reset`=0 during `HI` → next cycle `IDLE`, `OutValid`=0, `Result`=0x0000, `InReady`=1 after `Reset` returns high. A subsequent 0x0002 + 0x0003 → 0x0005.
